if_id_instr_queue: RTL

//  Fetch-to-decode instruction buffer. Sits between the IF stage and the ID stage.

---
 rtl/if_id_instr_queue_if.sv | 60 ++++++
 rtl/if_id_instr_queue.sv | 108 ++++++++++
 2 files changed

// File: rtl/if_id_instr_queue_if.sv
// Fetch/decode handshake bundle for the IF->ID instruction queue.
// Shared types for the fetched instruction entry live in if_id_pkg.
package if_id_pkg;
  typedef logic [63:0] bus64_t;
  typedef logic [31:0] instruction_t;

  typedef struct packed {
    bus64_t       pc;
    instruction_t instr;
    logic         xcpt;
  } fetch_entry_t;
endpackage

interface if_id_instr_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  fetch_valid_i;
  if_id_pkg::bus64_t       fetch_pc_i;
  if_id_pkg::instruction_t fetch_instr_i;
  logic                  fetch_xcpt_i;
  logic                  fetch_ready_o;

  logic                  decode_valid_o;
  if_id_pkg::bus64_t       decode_pc_o;
  if_id_pkg::instruction_t decode_instr_o;
  logic                  decode_xcpt_o;
  logic                  decode_ready_i;

  logic [CW-1:0]         count_o;

  modport master (
    output fetch_valid_i,
    output fetch_pc_i,
    output fetch_instr_i,
    output fetch_xcpt_i,
    input  fetch_ready_o,
    input  decode_valid_o,
    input  decode_pc_o,
    input  decode_instr_o,
    input  decode_xcpt_o,
    output decode_ready_i,
    input  count_o
  );

  modport slave (
    input  fetch_valid_i,
    input  fetch_pc_i,
    input  fetch_instr_i,
    input  fetch_xcpt_i,
    output fetch_ready_o,
    output decode_valid_o,
    output decode_pc_o,
    output decode_instr_o,
    output decode_xcpt_o,
    input  decode_ready_i,
    output count_o
  );
endinterface

// File: rtl/if_id_instr_queue.sv
// IF->ID instruction queue: DEPTH-entry FIFO of {pc, instr, xcpt}.
// Head is read combinationally; flush clears pointers and occupancy.
module if_id_instr_queue
  import if_id_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               flush_i,
  if_id_instr_queue_if.slave q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;

  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  fetch_entry_t in_ent;
  fetch_entry_t head;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Readiness depends only on stored occupancy, never on decode_ready_i.
  assign push = q.fetch_valid_i & ~full;
  assign pop  = ~empty & q.decode_ready_i;

  assign in_ent.pc    = q.fetch_pc_i;
  assign in_ent.instr = q.fetch_instr_i;
  assign in_ent.xcpt  = q.fetch_xcpt_i;

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = in_ent;
        wr_d        = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Payload storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head = mem_q[rd_q];
    if (empty) begin
      head.pc    = '0;
      head.instr = NOP_INSTR;
      head.xcpt  = 1'b0;
    end
  end

  assign q.fetch_ready_o  = ~full;
  assign q.decode_valid_o = ~empty;
  assign q.decode_pc_o    = head.pc;
  assign q.decode_instr_o = head.instr;
  assign q.decode_xcpt_o  = head.xcpt;
  assign q.count_o        = count_q;

  a_count_max: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    count_q <= CW'(DEPTH));

  a_no_pop_empty: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    !(pop && empty));

  a_no_push_full: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    !(push && full));

endmodule
